// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field offsets,
// sink FSM encoding and backpressure LFSR taps.
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } sink_st_e;

  localparam int PLD_LSB = 0;
  localparam int LFSR_W = 8;
  // Taps 8,6,5,4 of the Fibonacci LFSR
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  function automatic int dst_lsb(int ds);
    return ds;
  endfunction

  function automatic int last_bit(int ds, int as);
    return ds + as;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(
    logic [LFSR_W-1:0] l
  );
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic lfsr_stall(logic [LFSR_W-1:0] l);
    return l[0] & l[1];
  endfunction

endpackage

// File: rtl/stall_lfsr.sv
// Pseudo-random backpressure source; ready is
// registered so it never depends on the flit inputs.
module stall_lfsr
  import noc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst_i,
  output logic ready_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              ready_q;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      lfsr_q  <= SEED;
      ready_q <= 1'b1;
    end else begin
      lfsr_q  <= lfsr_d;
      ready_q <= ~lfsr_stall(lfsr_d);
    end
  end

  assign ready_o = ready_q;

endmodule

// File: rtl/pack_sink.sv
// NoC local-port packet sink: checks packets,
// counts good/bad packets and flits, flags idle.
module pack_sink
  import noc_pkg::*;
#(
  parameter int DATA_SIZE     = 8,
  parameter int ADDR_SIZE     = 4,
  parameter int ADDR          = 0,
  parameter int NODES_NUM     = 16,
  parameter int MAX_PACK_LEN  = 8,
  parameter int PACKS_TO_RECV = 16,
  parameter int IDLE_LIMIT    = 160,
  parameter logic [7:0] STALL_SEED = 8'hA5
) (
  input  logic                          clk,
  input  logic                          a_rst,
  input  logic [DATA_SIZE+ADDR_SIZE:0]  data_i,
  input  logic                          in_w,
  output logic                          in_r,
  output logic [15:0]                   packs_cnt,
  output logic [15:0]                   flits_cnt,
  output logic [7:0]                    err_cnt,
  output logic                          done,
  output logic                          timeout
);

  localparam int DST_LSB = dst_lsb(DATA_SIZE);
  localparam int LST_BIT = last_bit(DATA_SIZE, ADDR_SIZE);
  localparam int CW = $clog2(MAX_PACK_LEN + 2);
  localparam int IW = $clog2(IDLE_LIMIT + 2);
  localparam logic [31:0]   NODES_U = NODES_NUM;
  localparam logic [CW-1:0] MAX_L   = CW'(MAX_PACK_LEN);
  localparam logic [IW-1:0] IDLE_L  = IW'(IDLE_LIMIT);

  sink_st_e          st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d, n;
  logic [IW-1:0]     idle_q;
  logic [15:0]       packs_q, flits_q;
  logic [7:0]        err_q;
  logic              done_q;
  logic              xfer, last_f, head, err_f;
  logic              good, bad;
  logic [ADDR_SIZE-1:0] dst_f, src_f;

  stall_lfsr #(
    .SEED (STALL_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_i   (a_rst),
    .ready_o (in_r)
  );

  assign xfer   = in_w & in_r;
  assign last_f = data_i[LST_BIT];
  assign dst_f  = data_i[DST_LSB +: ADDR_SIZE];
  assign src_f  = data_i[PLD_LSB +: ADDR_SIZE];
  assign head   = (st_q == ST_IDLE);

  // Position of this flit in its packet, pinned at MAX once past it
  assign n = head ? CW'(1) :
             (cnt_q >= MAX_L) ? cnt_q : cnt_q + CW'(1);

  assign err_f =
    (dst_f != ADDR_SIZE'(ADDR)) |
    (head & ({{(32-ADDR_SIZE){1'b0}}, src_f} >= NODES_U)) |
    (~last_f & (n >= MAX_L));

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    good  = 1'b0;
    bad   = 1'b0;
    if (xfer) begin
      cnt_d = n;
      unique case (st_q)
        ST_IDLE: begin
          if (last_f) begin
            good  = ~err_f;
            bad   = err_f;
            cnt_d = '0;
          end else begin
            st_d = err_f ? ST_DROP : ST_RECV;
          end
        end
        ST_RECV: begin
          if (last_f) begin
            st_d  = ST_IDLE;
            good  = ~err_f;
            bad   = err_f;
            cnt_d = '0;
          end else if (err_f) begin
            st_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (last_f) begin
            st_d  = ST_IDLE;
            bad   = 1'b1;
            cnt_d = '0;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      packs_q <= '0;
      flits_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (xfer && flits_q != '1)
        flits_q <= flits_q + 16'd1;
      if (good && packs_q != '1)
        packs_q <= packs_q + 16'd1;
      if (bad && err_q != '1)
        err_q <= err_q + 8'd1;
      if (packs_q >= 16'(PACKS_TO_RECV))
        done_q <= 1'b1;
      if (xfer)
        idle_q <= '0;
      else if (idle_q != IDLE_L)
        idle_q <= idle_q + IW'(1);
    end
  end

  assign packs_cnt = packs_q;
  assign flits_cnt = flits_q;
  assign err_cnt   = err_q;
  assign done      = done_q;
  assign timeout   = (idle_q == IDLE_L);

endmodule

// File: tb/tb_pack_sink.sv
// Bench for pack_sink: packet-level model plus
// directed packets with hand-computed counts.
module tb_pack_sink;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1;
  logic [12:0] data0 = '0, data1 = '0;
  logic        in_w0 = 1'b0, in_w1 = 1'b0;
  logic        in_r0, in_r1;
  logic [15:0] packs0, flits0, packs1, flits1;
  logic [7:0]  err0, err1;
  logic        done0, done1, tmo0, tmo1;

  int nerr = 0;
  int ntot = 0;
  bit chk = 0;

  always #5 clk = ~clk;

  pack_sink #(
    .ADDR (3), .NODES_NUM (12), .STALL_SEED (8'h00)
  ) u0 (
    .clk (clk), .a_rst (a_rst), .data_i (data0),
    .in_w (in_w0), .in_r (in_r0),
    .packs_cnt (packs0), .flits_cnt (flits0),
    .err_cnt (err0), .done (done0), .timeout (tmo0)
  );

  pack_sink #(
    .ADDR (3), .STALL_SEED (8'hA5)
  ) u1 (
    .clk (clk), .a_rst (a_rst), .data_i (data1),
    .in_w (in_w1), .in_r (in_r1),
    .packs_cnt (packs1), .flits_cnt (flits1),
    .err_cnt (err1), .done (done1), .timeout (tmo1)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Packet-level reference: keep whole packet, judge it at its last flit
  int m_packs, m_flits, m_err, m_idle;
  bit m_done;
  logic [12:0] pq[$];
  int m1_flits;
  logic [7:0] l1;
  bit er1;

  always @(posedge clk) begin
    if (a_rst) begin
      m_packs = 0; m_flits = 0; m_err = 0;
      m_idle = 0; m_done = 0; pq.delete();
      m1_flits = 0; l1 = 8'hA5; er1 = 1;
    end else begin
      if (m_packs >= 16) m_done = 1;
      if (in_w0 && in_r0) begin
        if (m_flits < 65535) m_flits++;
        m_idle = 0;
        pq.push_back(data0);
        if (data0[12]) begin
          logic [12:0] h;
          bit b;
          h = pq[0];
          b = (pq.size() > 8) || (h[3:0] >= 12);
          foreach (pq[i])
            if (pq[i][11:8] != 4'd3) b = 1;
          if (b) begin
            if (m_err < 255) m_err++;
          end else if (m_packs < 65535) m_packs++;
          pq.delete();
        end
      end else if (m_idle < 160) m_idle++;
      if (in_w1 && in_r1) m1_flits++;
      l1 = {l1[6:0], l1[7] ^ l1[5] ^ l1[4] ^ l1[3]};
      er1 = !(l1[0] && l1[1]);
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("packs", packs0, m_packs);
      check("flits", flits0, m_flits);
      check("err", err0, m_err);
      check("done", done0, m_done);
      check("timeout", tmo0, m_idle == 160);
      check("in_r0", in_r0, 1);
      check("in_r1", in_r1, er1);
      check("flits1", flits1, m1_flits);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
  endtask

  task automatic send(input logic l, input logic [3:0] d,
                      input logic [7:0] p);
    bit ok;
    ok = 0;
    in_w0 = 1'b1;
    data0 = {l, d, p};
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_r0;
      @(posedge clk); #1;
    end
    in_w0 = 1'b0;
    if (!ok) check("send_budget", 0, 1);
  endtask

  task automatic pkt(input int len, input logic [3:0] d,
                     input logic [3:0] src);
    for (int i = 0; i < len; i++)
      send(i == len - 1, d, (i == 0) ? {4'h0, src} : 8'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rc;
    tick(2);
    a_rst = 1'b0;
    chk = 1;
    check("rst_packs", packs0, 0);
    check("rst_in_r", in_r0, 1);
    check("rst_in_r1", in_r1, 1);

    do_reset();
    pkt(3, 4'd3, 4'd5); tick(2);
    check("p3_packs", packs0, 1);
    check("p3_flits", flits0, 3);
    check("p3_err", err0, 0);

    do_reset();
    pkt(4, 4'd7, 4'd1); tick(1);
    check("bad_dst_err", err0, 1);
    check("bad_dst_packs", packs0, 0);
    check("bad_dst_flits", flits0, 4);
    pkt(1, 4'd3, 4'd2);
    check("after_drop_packs", packs0, 1);

    do_reset();
    pkt(10, 4'd3, 4'd1);
    check("long_err", err0, 1);
    pkt(2, 4'd3, 4'd1);
    check("long_next_packs", packs0, 1);
    pkt(8, 4'd3, 4'd1);
    check("max_len_packs", packs0, 2);
    check("max_len_flits", flits0, 20);

    do_reset();
    send(0, 4'd3, 8'h02); send(0, 4'd9, 8'h01);
    send(1, 4'd3, 8'h02);
    pkt(1, 4'd3, 4'd12);
    pkt(1, 4'd3, 4'd11);
    check("src_mid_err", err0, 2);
    check("src_mid_packs", packs0, 1);

    do_reset();
    for (int i = 0; i < 16; i++) pkt(1, 4'd3, 4'd0);
    check("p16_packs", packs0, 16);
    check("p16_done_pre", done0, 0);
    tick(1);
    check("p16_done", done0, 1);
    tick(3);
    pkt(1, 4'd3, 4'd0);
    check("p17_packs", packs0, 17);
    check("p17_done", done0, 1);

    do_reset();
    tick(159);
    check("idle159", tmo0, 0);
    tick(1);
    check("idle160", tmo0, 1);
    tick(5);
    check("idle_hold", tmo0, 1);
    pkt(1, 4'd3, 4'd0);
    check("idle_clr", tmo0, 0);

    do_reset();
    for (int i = 0; i < 260; i++) pkt(1, 4'd7, 4'd0);
    check("err_sat", err0, 255);
    check("err_sat_flits", flits0, 260);

    do_reset();
    send(0, 4'd3, 8'h01); send(0, 4'd3, 8'h01);
    do_reset();
    check("mid_rst_packs", packs0, 0);
    check("mid_rst_flits", flits0, 0);
    pkt(2, 4'd3, 4'd4);
    check("mid_rst_next", packs0, 1);
    check("mid_rst_err", err0, 0);

    rc = 0;
    in_w1 = 1'b1;
    data1 = {1'b1, 4'd3, 8'h00};
    repeat (200) begin
      @(negedge clk);
      if (in_r1) rc++;
      @(posedge clk);
    end
    #1;
    in_w1 = 1'b0;
    check("bp_flits", flits1, rc);
    check("bp_packs", packs1, rc);
    check("bp_stalls", (rc > 0 && rc < 200), 1);

    tick(2);
    chk = 0;
    $display("Result: errors=%0d of %0d checks", nerr, ntot);
    $finish;
  end

endmodule

// File: doc/pack_sink.md
PACK_SINK -- requirements
Module: pack_sink

Interface
REQ-001 Parameter DATA_SIZE, default 8: payload bits per flit.
REQ-002 Parameter ADDR_SIZE, default 4: node address bits.
REQ-003 Parameter ADDR, default 0: address of the node this sink serves.
REQ-004 Parameter NODES_NUM, default 16: number of nodes; valid source addresses are 0..NODES_NUM-1.
REQ-005 Parameter MAX_PACK_LEN, default 8: maximum flits per packet, head and last included.
REQ-006 Parameter PACKS_TO_RECV, default 16: packets expected before done.
REQ-007 Parameter IDLE_LIMIT, default 160: consecutive transfer-free cycles before timeout.
REQ-008 Parameter STALL_SEED, default 8'hA5: non-zero seed of the backpressure LFSR; 0 disables stalls.
REQ-009 clk  in  1  single clock; all logic on rising edge.
REQ-010 a_rst  in  1  reset, synchronous, active-high.
REQ-011 data_i  in  DATA_SIZE+ADDR_SIZE+1  flit from switch local port; [MSB]=last flag, next ADDR_SIZE bits=destination, low DATA_SIZE bits=payload.
REQ-012 in_w  in  1  flit valid from switch.
REQ-013 in_r  out  1  sink ready; transfer occurs on a cycle with in_w=1 and in_r=1.
REQ-014 packs_cnt  out  16  good packets received.
REQ-015 flits_cnt  out  16  flits accepted, good or bad.
REQ-016 err_cnt  out  8  bad packets received.
REQ-017 done  out  1  packs_cnt reached PACKS_TO_RECV.
REQ-018 timeout  out  1  IDLE_LIMIT cycles without a transfer.

Function
REQ-019 Packet: first transfer after IDLE is the head; payload[ADDR_SIZE-1:0] of the head is the source address; transfer with last flag=1 ends it; a head with last=1 is a 1-flit packet.
REQ-020 FSM states: IDLE (await head), RECV (inside good packet), DROP (inside bad packet, discard to last flit).
REQ-021 IDLE->RECV on head with last=0 and no error; IDLE->DROP on head with last=0 and error; head with last=1 stays in IDLE and is counted good or bad immediately.
REQ-022 Error conditions: destination != ADDR on any flit; head source >= NODES_NUM; flit count > MAX_PACK_LEN.
REQ-023 In RECV, an error flit moves FSM to DROP; last flit returns to IDLE, counting bad if in DROP or if this flit erred, else good.
REQ-024 Length overflow: when the MAX_PACK_LEN-th flit has last=0, it is an error and FSM enters DROP.
REQ-025 packs_cnt and err_cnt update one cycle after the last-flit transfer; flits_cnt updates one cycle after each transfer.
REQ-026 All counters saturate at all-ones; no wrap.
REQ-027 done is set one cycle after packs_cnt becomes PACKS_TO_RECV and stays high until reset; reception continues after done.
REQ-028 Idle counter clears on every transfer, increments otherwise, saturates at IDLE_LIMIT; timeout=1 while counter==IDLE_LIMIT; the next transfer clears timeout the following cycle.
REQ-029 in_r = ~stall, stall = LFSR[0] & LFSR[1]; 8-bit Fibonacci LFSR, taps 8,6,5,4, advances every cycle; STALL_SEED=0 gives in_r=1 constantly.
REQ-030 in_r is registered; it does not depend combinationally on in_w or data_i.
REQ-031 in_w while in_r=0 is not a transfer; the flit is not counted and the switch holds it.

Reset
REQ-032 With a_rst=1 on a rising edge: FSM=IDLE, all counters=0, done=0, timeout=0, LFSR=STALL_SEED, in_r=1.
REQ-033 Reset mid-packet discards the partial packet with no count; the next transfer is a head.

Structure
REQ-034 Flit field offsets, the FSM state encoding and LFSR taps are placed in shared package noc_pkg, which is also used by fabric and switch.
REQ-035 The LFSR is a separate sub-module, stall_lfsr, parameterised by its seed.

Verification
REQ-036 STALL_SEED=0, ADDR=3: 3-flit packet dest=3 src=5 -> packs_cnt=1, flits_cnt=3, err_cnt=0.
REQ-037 Head dest=7 with ADDR=3, 4 flits -> err_cnt=1, packs_cnt=0, flits_cnt=4, FSM IDLE after last.
REQ-038 MAX_PACK_LEN=8, 10-flit packet to self -> err_cnt=1 and the next 2-flit good packet gives packs_cnt=1.
REQ-039 PACKS_TO_RECV=16, 16 good 1-flit packets -> done=1 one cycle after the 16th count and held; the 17th packet gives packs_cnt=17.
REQ-040 No in_w for 160 cycles -> timeout=1 at cycle 160; one transfer -> timeout=0 the next cycle.
REQ-041 Reset asserted after flit 2 of 5 -> counters=0; the following good 2-flit packet gives packs_cnt=1. With STALL_SEED=8'hA5, in_w held for 200 cycles -> flits_cnt equals the count of in_r=1 cycles.
